// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by spi_controller and spi_driver.
//   - spi_state_e   : frame FSM state encoding
//   - SPI mode-0 line levels (sck idle low, ss active low)
//   - spi_half_period(): sysclk cycles per sck half period
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } spi_state_e;

    // Mode 0: CPOL=0 (sck idles low), CPHA=0 (sample on rising edge).
    localparam logic SCK_IDLE  = 1'b0;
    localparam logic SS_ACTIVE = 1'b0;
    localparam logic SS_IDLE   = 1'b1;

    // Integer division; callers need a result of at least 3 so the cipo
    // synchronizer settles well inside one sck half period.
    function automatic int spi_half_period(input int sysclk_mhz, input int spi_khz);
        return (sysclk_mhz * 1000) / (2 * spi_khz);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: free-running half-period counter for the SPI controller.
// Counts 0..HALF-1 and pulses half_tick on the last count. Held at zero
// while clr is high so the first half period after leaving idle is full.
// Ports:
//   sysclk    in  system clock
//   sysreset  in  asynchronous active-high reset
//   clr       in  hold counter at zero
//   half_tick out one-cycle pulse marking the final cycle of a half period
module spi_clk_div #(
    parameter int unsigned HALF = 13
) (
    input  logic sysclk,
    input  logic sysreset,
    input  logic clr,
    output logic half_tick
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        half_tick = (cnt_q == CW'(HALF - 1));
        cnt_d     = cnt_q + CW'(1);
        if (clr || half_tick) cnt_d = '0;
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI master, mode 0, MSB first, one ss-low window per frame.
// Sends FRAME_BYTES bytes from tx_data (byte 0 first) and captures the reply
// into rx_data with the same byte mapping.
// Build option: define SPI_CTRL_BYTE_GAP_EN to insert GAP_HALVES idle sck
// half periods between bytes (none after the last byte).
// Ports:
//   sysclk, sysreset     clock, asynchronous active-high reset
//   start                1-cycle request, accepted only while idle
//   tx_data              frame to send, latched when start is accepted
//   rx_data              last completed received frame
//   busy                 high from the cycle after accept through done
//   done                 1-cycle pulse, rx_data valid from this cycle
//   device_ss/clk/copi   SPI outputs (ss active low, sck idle low)
//   device_cipo          SPI input, asynchronous to sysclk
module spi_controller
    import spi_pkg::*;
#(
    parameter int SYSCLK_MHZ  = 27,
    parameter int SPI_KHZ     = 1000,
    parameter int FRAME_BYTES = 256,
    parameter int GAP_HALVES  = 2
) (
    input  logic                     sysclk,
    input  logic                     sysreset,
    input  logic                     start,
    input  logic [FRAME_BYTES*8-1:0] tx_data,
    output logic [FRAME_BYTES*8-1:0] rx_data,
    output logic                     busy,
    output logic                     done,
    output logic                     device_ss,
    output logic                     device_clk,
    output logic                     device_copi,
    input  logic                     device_cipo
);

    localparam int H  = spi_half_period(SYSCLK_MHZ, SPI_KHZ);
    localparam int N  = FRAME_BYTES * 8;
    localparam int BW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

    spi_state_e    state_q, state_d;
    logic [N-1:0]  tx_sh_q, tx_sh_d;
    logic [N-1:0]  rx_sh_q, rx_sh_d;
    logic [N-1:0]  rx_data_q, rx_data_d;
    logic [2:0]    bit_q, bit_d;
    logic [BW-1:0] byte_q, byte_d;
    logic          phase_q, phase_d;     // 0: sck low phase, 1: sck high phase
    logic          ss_q, ss_d;
    logic          sck_q, sck_d;
    logic          cipo_meta_q, cipo_meta_d;
    logic          cipo_sync_q, cipo_sync_d;
    logic          half_tick;
    logic          last_bit, last_byte;

    // Shift registers run in wire order (first bit on the wire at N-1),
    // so the byte order is reversed between the ports and the shifters.
    logic [N-1:0]  tx_lin;
    logic [N-1:0]  rx_frame;

    for (genvar k = 0; k < FRAME_BYTES; k++) begin : g_map
        assign tx_lin[N-1-8*k -: 8]  = tx_data[8*k +: 8];
        assign rx_frame[8*k +: 8]    = rx_sh_q[N-1-8*k -: 8];
    end

`ifdef SPI_CTRL_BYTE_GAP_EN
    localparam int GW = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;
    logic [GW-1:0] gap_q, gap_d;
`else
    logic unused_gap_cfg;
    assign unused_gap_cfg = (GAP_HALVES != 0);
`endif

    spi_clk_div #(.HALF(H)) u_clk_div (
        .sysclk    (sysclk),
        .sysreset  (sysreset),
        .clr       (state_q == ST_IDLE),
        .half_tick (half_tick)
    );

    always_comb begin
        state_d     = state_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        phase_d     = phase_q;
        ss_d        = ss_q;
        sck_d       = sck_q;
        cipo_meta_d = device_cipo;
        cipo_sync_d = cipo_meta_q;
`ifdef SPI_CTRL_BYTE_GAP_EN
        gap_d       = gap_q;
`endif
        last_bit    = (bit_q == 3'd7);
        last_byte   = (byte_q == BW'(FRAME_BYTES - 1));

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETUP;
                    tx_sh_d = tx_lin;       // copi shows bit 7 of byte 0 now
                    ss_d    = SS_ACTIVE;
                    sck_d   = SCK_IDLE;
                    bit_d   = '0;
                    byte_d  = '0;
                    phase_d = 1'b0;
                end
            end
            ST_SETUP: begin
                if (half_tick) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (half_tick) begin
                    if (!phase_q) begin
                        sck_d   = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        // Last cycle of the high phase: sample, then fall and
                        // present the next bit on copi.
                        sck_d   = SCK_IDLE;
                        phase_d = 1'b0;
                        rx_sh_d = {rx_sh_q[N-2:0], cipo_sync_q};
                        tx_sh_d = tx_sh_q << 1;
                        bit_d   = bit_q + 3'd1;
                        if (last_bit) begin
                            if (last_byte) begin
                                state_d = ST_HOLD;
                            end else begin
                                byte_d = byte_q + BW'(1);
`ifdef SPI_CTRL_BYTE_GAP_EN
                                state_d = ST_GAP;
                                gap_d   = '0;
`endif
                            end
                        end
                    end
                end
            end
            ST_GAP: begin
`ifdef SPI_CTRL_BYTE_GAP_EN
                if (half_tick) begin
                    if (gap_q == GW'(GAP_HALVES - 1)) state_d = ST_SHIFT;
                    else                              gap_d   = gap_q + GW'(1);
                end
`else
                state_d = ST_SHIFT;
`endif
            end
            ST_HOLD: begin
                if (half_tick) begin
                    ss_d      = SS_IDLE;
                    rx_data_d = rx_frame;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            state_q     <= ST_IDLE;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            phase_q     <= 1'b0;
            ss_q        <= SS_IDLE;
            sck_q       <= SCK_IDLE;
            cipo_meta_q <= 1'b0;
            cipo_sync_q <= 1'b0;
`ifdef SPI_CTRL_BYTE_GAP_EN
            gap_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            phase_q     <= phase_d;
            ss_q        <= ss_d;
            sck_q       <= sck_d;
            cipo_meta_q <= cipo_meta_d;
            cipo_sync_q <= cipo_sync_d;
`ifdef SPI_CTRL_BYTE_GAP_EN
            gap_q       <= gap_d;
`endif
        end
    end

    // tx_sh empties as bits go out, so copi rests at 0 between frames.
    assign device_copi = tx_sh_q[N-1];
    assign device_ss   = ss_q;
    assign device_clk  = sck_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign rx_data     = rx_data_q;

endmodule

// File: tb/tb_spi_controller.sv
module tb_spi_controller;
    localparam int FB = 4;
`ifdef SPI_CTRL_BYTE_GAP_EN
    localparam int EXP_LAT    = 938;
    localparam int EXP_LO_MAX = 39;   // 2 gap halves + the normal low half
`else
    localparam int EXP_LAT    = 860;
    localparam int EXP_LO_MAX = 13;
`endif

    logic          sysclk = 1'b0;
    logic          sysreset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   tx_data = '0;
    logic [31:0]   rx_data;
    logic          busy, done, device_ss, device_clk, device_copi;
    logic          device_cipo = 1'b0;

    spi_controller #(.SYSCLK_MHZ(27), .SPI_KHZ(1000), .FRAME_BYTES(FB), .GAP_HALVES(2)) dut (
        .sysclk(sysclk), .sysreset(sysreset), .start(start), .tx_data(tx_data),
        .rx_data(rx_data), .busy(busy), .done(done), .device_ss(device_ss),
        .device_clk(device_clk), .device_copi(device_copi), .device_cipo(device_cipo)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // byte 0 first, MSB first: wire order equals byte-reversed word
    function automatic logic [31:0] lin(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // ---------------- mode-0 peripheral model + sck monitor ----------------
    logic [31:0] per_tx = '0;
    logic [31:0] per_sh = '0;
    logic [31:0] per_rx = '0;
    logic        prev_ss = 1'b1, prev_clk = 1'b0;
    int cyc = 0, t_ss_fall = 0, t_rise = 0, t_fall = 0;
    int rises = 0, first_dly = 0, hold_len = 0, done_cnt = 0;
    int hi_min = 0, hi_max = 0, lo_min = 0, lo_max = 0;

    always @(negedge sysclk) begin
        int len;
        cyc++;
        if (done === 1'b1) done_cnt++;
        if (prev_ss && !device_ss) begin
            t_ss_fall = cyc; rises = 0; per_rx = '0;
            hi_min = 9999; hi_max = 0; lo_min = 9999; lo_max = 0;
            per_sh = lin(per_tx);
            device_cipo = per_sh[31];
        end
        if (!prev_ss && device_ss) hold_len = cyc - t_fall;
        if (!device_ss && !prev_clk && device_clk) begin
            rises++;
            per_rx = {per_rx[30:0], device_copi};
            if (rises == 1) first_dly = cyc - t_ss_fall;
            else begin
                len = cyc - t_fall;
                if (len < lo_min) lo_min = len;
                if (len > lo_max) lo_max = len;
            end
            t_rise = cyc;
        end
        if (!device_ss && prev_clk && !device_clk) begin
            len = cyc - t_rise;
            if (len < hi_min) hi_min = len;
            if (len > hi_max) hi_max = len;
            t_fall = cyc;
            per_sh = per_sh << 1;
            device_cipo = per_sh[31];
        end
        prev_ss = device_ss;
        prev_clk = device_clk;
    end

    // Launch a frame and wait for done. lat counts the start cycle and the
    // done cycle inclusively. poke adds ignored start pulses at cycles 5/100.
    // tx_data is scrambled mid-frame to prove it was latched.
    task automatic run_frame(input logic [31:0] tx, input bit poke,
                             output int lat, output bit busy_gap);
        busy_gap = 1'b0;
        @(negedge sysclk);
        tx_data = tx; start = 1'b1; lat = 1;
        while (lat < 3000) begin
            @(negedge sysclk);
            lat++;
            start = poke && (lat == 5 || lat == 100);
            if (lat == 50) tx_data = ~tx;
            if (done) break;
            if (!busy) busy_gap = 1'b1;
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [31:0] tx;
        logic [31:0] per;
        logic [31:0] exp_rx;
        logic [31:0] exp_copi;   // bits seen on copi, wire order
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lat, n, d0;
        bit gap;

        vecs[0] = '{32'hA5C3_0F81, 32'h1234_5678, 32'h1234_5678, 32'h810F_C3A5};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[2] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3] = '{32'h8000_0001, 32'h0F00_00F0, 32'h0F00_00F0, 32'h0100_0080};
        vecs[4] = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hEFBE_ADDE};

        // reset state
        repeat (3) @(negedge sysclk);
        check("rst_ss", device_ss, 1);
        check("rst_clk", device_clk, 0);
        check("rst_copi", device_copi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rx", rx_data, 0);
        sysreset = 1'b0;
        repeat (2) @(negedge sysclk);

        // table-driven frames
        for (int i = 0; i < 5; i++) begin
            per_tx = vecs[i].per;
            d0 = done_cnt;
            run_frame(vecs[i].tx, (i == 0), lat, gap);
            check($sformatf("v%0d_latency", i), lat, EXP_LAT);
            check($sformatf("v%0d_rx", i), rx_data, vecs[i].exp_rx);
            check($sformatf("v%0d_copi", i), per_rx, vecs[i].exp_copi);
            check($sformatf("v%0d_rises", i), rises, 32);
            @(negedge sysclk);
            check($sformatf("v%0d_done_pulse", i), done, 0);
            check($sformatf("v%0d_idle", i), busy, 0);
            check($sformatf("v%0d_done_cnt", i), done_cnt - d0, 1);
            if (i == 0) begin
                check("busy_continuous", gap, 0);
                check("sck_hi_min", hi_min, 13);
                check("sck_hi_max", hi_max, 13);
                check("sck_lo_min", lo_min, 13);
                check("sck_lo_max", lo_max, EXP_LO_MAX);
                check("ss_to_first_rise", first_dly, 26);
                check("last_fall_to_ss_rise", hold_len, 13);
            end
        end

        // reset in the middle of bit 17: immediate abort, no done
        per_tx = 32'h0;
        d0 = done_cnt;
        @(negedge sysclk); tx_data = 32'h5A5A_5A5A; start = 1'b1;
        @(negedge sysclk); start = 1'b0;
        n = 0;
        while (rises < 17 && n < 2000) begin @(negedge sysclk); n++; end
        check("reach_bit17", (rises >= 17), 1);
        @(posedge sysclk); #2;
        sysreset = 1'b1;
        #1;
        check("abort_ss", device_ss, 1);
        check("abort_clk", device_clk, 0);
        check("abort_busy", busy, 0);
        check("abort_rx", rx_data, 0);
        repeat (3) @(negedge sysclk);
        sysreset = 1'b0;
        repeat (3) @(negedge sysclk);
        check("abort_no_done", done_cnt - d0, 0);

        // clean frame after abort
        per_tx = 32'h1357_9BDF;
        run_frame(32'h0246_8ACE, 1'b0, lat, gap);
        check("post_abort_latency", lat, EXP_LAT);
        check("post_abort_rx", rx_data, 32'h1357_9BDF);
        check("post_abort_copi", per_rx, 32'hCE8A_4602);

        // start coincident with DONE ignored; one cycle later accepted
        per_tx = 32'h00FF_FF00;
        tx_data = 32'h6655_4433; start = 1'b1;       // this is the DONE cycle
        @(negedge sysclk);
        check("start_in_done_ignored", busy, 0);
        @(negedge sysclk);
        start = 1'b0;
        check("b2b_accepted", busy, 1);
        tx_data = 32'h0;
        n = 0;
        while (!done && n < 3000) begin @(negedge sysclk); n++; end
        check("b2b_done_seen", done, 1);
        check("b2b_rx", rx_data, 32'h00FF_FF00);
        check("b2b_copi", per_rx, 32'h3344_5566);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
